sys_array_output_collector: RTL and testbench

//  Receive end of sys_array_basic. Takes skewed per-column results from output_data: column j of

---
 rtl/sys_array_output_collector_if.sv | 18 +
 rtl/sys_array_output_collector.sv | 149 ++++++++++++++
 tb/tb_sys_array_output_collector.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_array_output_collector_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_array_output_collector_if : aligned result-row stream (valid/ready)
// Rev 1.0
// ---------------------------------------------------------------------------
interface sys_array_output_collector_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int ARRAY_MAX_W = 10
);
   logic                                       res_valid;
   logic                                       res_ready;
   logic                                       res_last;
   logic [0:ARRAY_MAX_W-1][2*DATA_WIDTH-1:0]   res_data;

   modport master (output res_valid, res_data, res_last, input res_ready);
   modport slave  (input res_valid, res_data, res_last, output res_ready);
endinterface
`default_nettype wire

// File: rtl/sys_array_output_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_array_output_collector : deskews systolic column results into rows,
// buffers them in a FIFO and streams them out with valid/ready.
// Rev 1.0
// ---------------------------------------------------------------------------
module sys_array_output_collector #(
   parameter int DATA_WIDTH  = 8,
   parameter int ARRAY_MAX_W = 10,
   parameter int ARRAY_MAX_L = 10,
   parameter int PIPE_LAT    = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int ROW_CNT_W   = 8
)(
   input  wire logic                                     clk,
   input  wire logic                                     reset,
   input  wire logic                                     start,
   input  wire logic [$clog2(ARRAY_MAX_L)-1:0]           array_w_l,
   input  wire logic [ROW_CNT_W-1:0]                     num_rows,
   input  wire logic [0:ARRAY_MAX_W-1][2*DATA_WIDTH-1:0] output_data,
   sys_array_output_collector_if.master                  res_if,
   output logic                                          busy,
   output logic                                          overflow
);
   localparam int RW        = 2*DATA_WIDTH;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = $clog2(FIFO_DEPTH+1);
   localparam int WAIT_W    = $clog2(ARRAY_MAX_L+PIPE_LAT+ARRAY_MAX_W);
   localparam int WAIT_BASE = PIPE_LAT + ARRAY_MAX_W - 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COLLECT, S_DRAIN} state_t;

   state_t                 r_state, w_state_nxt;
   logic [WAIT_W-1:0]      r_wait_cnt, w_wait_nxt;
   logic [ROW_CNT_W-1:0]   r_row_cnt, w_row_nxt, r_num_rows;
   logic                   r_overflow;
   logic                   w_push_req, w_push_last, w_push, w_pop, w_drop, w_full, w_valid;
   logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]       r_count;
   logic [0:ARRAY_MAX_W-1][RW-1:0] r_mem [FIFO_DEPTH];
   logic                   r_mem_last [FIFO_DEPTH];
   wire  logic [0:ARRAY_MAX_W-1][RW-1:0] w_aligned;

   // Column j needs ARRAY_MAX_W-1-j stages so every column of a row lines up
   for (genvar j = 0; j < ARRAY_MAX_W; j++) begin : g_col
      if (j == ARRAY_MAX_W-1) begin : g_direct
         assign w_aligned[j] = output_data[j];
      end else begin : g_dly
         localparam int N = ARRAY_MAX_W-1-j;
         logic [RW-1:0] r_dly [N];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int s = 0; s < N; s++) r_dly[s] <= '0;
            end else begin
               r_dly[0] <= output_data[j];
               for (int s = 1; s < N; s++) r_dly[s] <= r_dly[s-1];
            end
         end
         assign w_aligned[j] = r_dly[N-1];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_row_nxt   = r_row_cnt;
      w_push_req  = 1'b0;
      w_push_last = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && (num_rows != '0)) begin
               w_state_nxt = S_WAIT;
               w_wait_nxt  = WAIT_W'(array_w_l) + WAIT_W'(WAIT_BASE);
               w_row_nxt   = '0;
            end
         end
         S_WAIT: begin
            // Leave on the cycle the count reaches zero so COLLECT lands on A_0
            w_wait_nxt = r_wait_cnt - WAIT_W'(1);
            if (r_wait_cnt <= WAIT_W'(1)) w_state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            w_push_req = 1'b1;
            w_row_nxt  = r_row_cnt + ROW_CNT_W'(1);
            if (r_row_cnt == r_num_rows - ROW_CNT_W'(1)) begin
               w_push_last = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_row_cnt  <= '0;
         r_num_rows <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_row_cnt  <= w_row_nxt;
         if ((r_state == S_IDLE) && start) begin
            r_num_rows <= num_rows;
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop   = w_valid & res_if.res_ready;
   assign w_push  = w_push_req & (~w_full | w_pop);
   assign w_drop  = w_push_req & w_full & ~w_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i]      <= '0;
            r_mem_last[i] <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr]      <= w_aligned;
            r_mem_last[r_wr_ptr] <= w_push_last;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   assign res_if.res_valid = w_valid;
   assign res_if.res_data  = w_valid ? r_mem[r_rd_ptr] : '0;
   assign res_if.res_last  = w_valid ? r_mem_last[r_rd_ptr] : 1'b0;
   assign busy             = (r_state != S_IDLE);
   assign overflow         = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_sys_array_output_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sys_array_output_collector : directed passes checked against a row-level
// queue model of the collector. Rev 1.0
// ---------------------------------------------------------------------------
module tb_sys_array_output_collector;
   localparam int DW = 8, W = 10, L = 10, PL = 1, FD = 4, RCW = 8, RW = 16;
   localparam int AWL_W = $clog2(L);
   typedef logic [0:W-1][RW-1:0] row_t;
   typedef struct { row_t data; logic last; } ent_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [AWL_W-1:0]  array_w_l = '0;
   logic [RCW-1:0]    num_rows = '0;
   row_t              output_data = '0;
   logic              busy, overflow;

   sys_array_output_collector_if #(.DATA_WIDTH(DW), .ARRAY_MAX_W(W)) res_if ();

   sys_array_output_collector #(
      .DATA_WIDTH(DW), .ARRAY_MAX_W(W), .ARRAY_MAX_L(L),
      .PIPE_LAT(PL), .FIFO_DEPTH(FD), .ROW_CNT_W(RCW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .array_w_l(array_w_l),
      .num_rows(num_rows), .output_data(output_data), .res_if(res_if.master),
      .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Array-side stimulus: column j of vector k appears in cycle D+k+j of the pass
   int drv_t0 = -1000, drv_D = 0, drv_n = 0;
   initial begin : drv_p
      int k;
      forever begin
         @(posedge clk); #2;
         for (int j = 0; j < W; j++) begin
            k = cyc - drv_t0 - drv_D - j;
            if (k >= 0 && k < drv_n) output_data[j] = RW'(100*k + j);
            else                     output_data[j] = RW'(16'hEE00 + j);
         end
      end
   end

   // Row-level model: row k is offered at end of cycle A_k; a queue stands in for the FIFO
   initial begin : model_p
      ent_t mq[$];
      ent_t e;
      logic m_busy, m_ovf, busy_now, pop;
      int   m_t0, m_A0, m_n, c, k;
      m_busy = 0; m_ovf = 0; m_t0 = 0; m_A0 = 0; m_n = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mq.delete();
            m_busy = 0;
            m_ovf  = 0;
         end else begin
            chk("busy", busy, m_busy);
            chk("overflow", overflow, m_ovf);
            chk("res_valid", res_if.res_valid, mq.size() != 0);
            if (mq.size() != 0) begin
               chk("res_data", res_if.res_data, mq[0].data);
               chk("res_last", res_if.res_last, mq[0].last);
            end
            c = cyc - m_t0;
            busy_now = m_busy;
            pop = (mq.size() != 0) && res_if.res_ready;
            if (pop) void'(mq.pop_front());
            if (busy_now && c >= m_A0 && c < m_A0 + m_n) begin
               k = c - m_A0;
               for (int j = 0; j < W; j++) e.data[j] = RW'(100*k + j);
               e.last = (k == m_n - 1);
               if (mq.size() < FD) mq.push_back(e);
               else                m_ovf = 1;
            end
            if (busy_now && c >= m_A0 + m_n && mq.size() == 0) m_busy = 0;
            if (!busy_now && start) begin
               m_ovf = 0;
               if (num_rows != 0) begin
                  m_busy = 1;
                  m_t0   = cyc;
                  m_A0   = int'(array_w_l) + PL + 1 + W - 1;
                  m_n    = int'(num_rows);
               end
            end
         end
      end
   end

   int p_t0 = 0;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic go(input int aw, input int n, input bit drive);
      array_w_l = AWL_W'(aw);
      num_rows  = RCW'(n);
      start     = 1'b1;
      if (drive) begin
         p_t0 = cyc; drv_t0 = cyc; drv_D = aw + PL + 1; drv_n = n;
      end
      tick();
      start = 1'b0;
   endtask

   // Lands 3 time units into cycle c of the current pass
   task automatic at(input int c);
      while (cyc < p_t0 + c) tick();
      #2;
   endtask

   task automatic wait_idle(input int max, input bit toggle);
      int i;
      i = 0;
      while ((busy || res_if.res_valid) && i < max) begin
         if (toggle) res_if.res_ready = ~res_if.res_ready;
         tick();
         i++;
      end
      checks++;
      if (busy || res_if.res_valid) begin
         errors++;
         $display("FAIL wait_idle: timeout busy=%0b valid=%0b required 0 0", busy, res_if.res_valid);
      end
   endtask

   initial begin
      res_if.res_ready = 1'b1;
      repeat (3) tick();
      #2;
      chk("rst res_valid", res_if.res_valid, 0);
      chk("rst res_data", res_if.res_data, 0);
      chk("rst res_last", res_if.res_last, 0);
      chk("rst busy", busy, 0);
      chk("rst overflow", overflow, 0);
      tick(); reset = 1'b0;
      repeat (2) tick();

      // T1: five rows, consumer always ready
      go(1, 5, 1);
      at(12); chk("T1 valid c12", res_if.res_valid, 0);
      at(13); chk("T1 valid c13", res_if.res_valid, 1);
              chk("T1 row0 col0", res_if.res_data[0], 0);
              chk("T1 row0 col4", res_if.res_data[4], 4);
              chk("T1 row0 col9", res_if.res_data[9], 9);
      at(17); chk("T1 row4 col0", res_if.res_data[0], 400);
              chk("T1 row4 last", res_if.res_last, 1);
              chk("T1 busy c17", busy, 1);
      at(18); chk("T1 busy c18", busy, 0);
      wait_idle(50, 0);
      tick();

      // T2: consumer stalled until cycle 30, last row overflows
      res_if.res_ready = 1'b0;
      go(1, 5, 1);
      at(20); chk("T2 overflow", overflow, 1);
              chk("T2 head col0", res_if.res_data[0], 0);
              chk("T2 head last", res_if.res_last, 0);
      at(30); res_if.res_ready = 1'b1;
      at(33); chk("T2 busy c33", busy, 1);
      at(34); chk("T2 busy c34", busy, 0);
              chk("T2 overflow sticky", overflow, 1);
      tick();

      // T3: ready toggling every cycle
      go(1, 3, 1);
      wait_idle(100, 1);
      res_if.res_ready = 1'b1;
      chk("T3 overflow", overflow, 0);
      tick();

      // T4: start while busy is ignored; start with zero rows does nothing
      go(1, 4, 1);
      at(5);
      go(3, 7, 0);
      wait_idle(100, 0);
      go(0, 0, 0);
      repeat (3) begin
         tick();
         chk("T4 zero busy", busy, 0);
         chk("T4 zero valid", res_if.res_valid, 0);
      end

      // T5: asynchronous reset in the middle of COLLECT
      go(1, 5, 1);
      at(14);
      reset = 1'b1;
      #1;
      chk("T5 res_valid", res_if.res_valid, 0);
      chk("T5 res_data", res_if.res_data, 0);
      chk("T5 res_last", res_if.res_last, 0);
      chk("T5 busy", busy, 0);
      tick(); tick();
      reset = 1'b0;
      tick();
      go(1, 5, 1);
      at(13); chk("T5 pass2 valid", res_if.res_valid, 1);
              chk("T5 pass2 col3", res_if.res_data[3], 3);
      wait_idle(50, 0);
      tick();

      // T6: full-length array, single row
      go(9, 1, 1);
      at(20); chk("T6 valid c20", res_if.res_valid, 0);
      at(21); chk("T6 valid c21", res_if.res_valid, 1);
              chk("T6 last", res_if.res_last, 1);
              chk("T6 col9", res_if.res_data[9], 9);
      wait_idle(50, 0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
